// File: rtl/counter_share_arbiter_pkg.sv
// Shared types and defaults for the counter-sharing arbiter.
// Holds the job FSM encoding and a one-hot to index helper.
package counter_share_arbiter_pkg;

    localparam int unsigned DefNreq = 2;
    localparam int unsigned DefW    = 4;
    localparam int unsigned DefLW   = 4;
    localparam int unsigned MaxNreq = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StSample,
        StDone
    } state_e;

    // Index of the set bit; returns 0 for an all-zero vector.
    function automatic int unsigned onehot_idx(input logic [MaxNreq-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MaxNreq; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/counter_share_arbiter_if.sv
// Requester-side bus of the counter-sharing arbiter: job requests in,
// grants, done pulses and the captured result out.
interface counter_share_arbiter_if
    import counter_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = DefNreq,
    parameter int unsigned W    = DefW,
    parameter int unsigned LW   = DefLW
);

    logic [NREQ-1:0]    req;
    logic [NREQ*W-1:0]  start_val;
    logic [NREQ*LW-1:0] run_len;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [W-1:0]       result;
    logic               busy;

    modport master (
        output req,
        output start_val,
        output run_len,
        input  gnt,
        input  done,
        input  result,
        input  busy
    );

    modport slave (
        input  req,
        input  start_val,
        input  run_len,
        output gnt,
        output done,
        output result,
        output busy
    );

endinterface

// File: rtl/counter_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick starting at the pointer;
// the pointer moves past the finished winner when advance is strobed.
module rr_arbiter
    import counter_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = DefNreq
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    input  logic [NREQ-1:0] adv_gnt,
    output logic [NREQ-1:0] gnt
);

    localparam int unsigned PW = $clog2(NREQ);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned j;
        logic [PW-1:0] j_idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        j     = 0;
        j_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = 32'(ptr_q) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            j_idx = PW'(j);
            if (!found && req[j_idx]) begin
                gnt[j_idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        int unsigned nxt;
        nxt = onehot_idx(MaxNreq'(adv_gnt)) + 32'd1;
        if (nxt >= NREQ) begin
            nxt = 0;
        end
        ptr_d = PW'(nxt);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/counter_share_arbiter.sv
// Shares one loadable free-running counter among NREQ requesters: each job
// loads S, runs L cycles, samples S+L through the counter's output enable.
module counter_share_arbiter
    import counter_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = DefNreq,
    parameter int unsigned W    = DefW,
    parameter int unsigned LW   = DefLW
) (
    input  logic                   clk,
    input  logic                   rstn,
    counter_share_arbiter_if.slave bus,
    output logic                   cnt_ld,
    output logic [W-1:0]           cnt_loadin,
    output logic                   cnt_oe,
    input  logic [W-1:0]           cnt_dout
);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]    s_q, s_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [W-1:0]    result_q, result_d;
    logic [NREQ-1:0] arb_gnt;
    logic            arb_adv;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (bus.req),
        .advance (arb_adv),
        .adv_gnt (gnt_q),
        .gnt     (arb_gnt)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        s_d      = s_q;
        len_d    = len_q;
        rem_d    = rem_q;
        result_d = result_q;
        arb_adv  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    gnt_d = arb_gnt;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (arb_gnt[i]) begin
                            s_d   = bus.start_val[i*W +: W];
                            len_d = bus.run_len[i*LW +: LW];
                        end
                    end
                    state_d = StLoad;
                end
            end
            StLoad: begin
                rem_d   = len_q;
                state_d = (len_q != '0) ? StRun : StSample;
            end
            StRun: begin
                rem_d = rem_q - 1'b1;
                if (rem_q == LW'(1)) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                result_d = cnt_dout;
                state_d  = StDone;
            end
            StDone: begin
                gnt_d   = '0;
                arb_adv = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            s_q      <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            s_q      <= s_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    // Outputs decode only from state and registers; no path from req.
    assign cnt_ld     = (state_q == StLoad);
    assign cnt_oe     = (state_q == StSample);
    assign cnt_loadin = s_q;
    assign bus.gnt    = gnt_q;
    assign bus.done   = gnt_q & {NREQ{state_q == StDone}};
    assign bus.result = result_q;
    assign bus.busy   = (state_q != StIdle);

endmodule
